// File: rtl/ex_ma_datapath.sv
// ---------------------------------------------------------------------------
// ex_ma_datapath
//   Execute + memory-access slice of the 5-stage pipeline.
//   EX  : combinational ALU, address generation and branch resolution.
//   EX/MA register : captures result, instruction, class and store data.
//   MA  : word-addressed data memory (combinational read, clocked write)
//         and selection of the value returned to the register file.
//
// Ports
//   clk                   in   rising-edge clock
//   rst_n                 in   synchronous active-low reset (pipeline reg only)
//   Inst_In         [31:0] in   instruction from ID/EX
//   Operand_A_val_In[31:0] in   rs1 value
//   Operand_B_val_In[31:0] in   rs2 value / store data
//   Immx_Data_In    [31:0] in   sign-extended immediate
//   Inst_Type_In    [4:0]  in   instruction class (0 NOP .. 6 LUI, others NOP)
//   EX_isBranchTaken_Out   out  combinational branch decision
//   EX_Result_Out   [31:0] out  combinational ALU result / address / target
//   MA_Register_Data_Out   out  load data or registered result
//   MA_Inst_Out     [31:0] out  instruction held in EX/MA
//   EX_MA_Inst_Type_Out[4:0] out class held in EX/MA
// ---------------------------------------------------------------------------
module ex_ma_datapath #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Inst_In,
  input  logic [31:0] Operand_A_val_In,
  input  logic [31:0] Operand_B_val_In,
  input  logic [31:0] Immx_Data_In,
  input  logic [4:0]  Inst_Type_In,
  output logic        EX_isBranchTaken_Out,
  output logic [31:0] EX_Result_Out,
  output logic [31:0] MA_Register_Data_Out,
  output logic [31:0] MA_Inst_Out,
  output logic [4:0]  EX_MA_Inst_Type_Out
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [4:0] TYPE_NOP    = 5'd0;
  localparam logic [4:0] TYPE_R_ALU  = 5'd1;
  localparam logic [4:0] TYPE_I_ALU  = 5'd2;
  localparam logic [4:0] TYPE_LOAD   = 5'd3;
  localparam logic [4:0] TYPE_STORE  = 5'd4;
  localparam logic [4:0] TYPE_BRANCH = 5'd5;
  localparam logic [4:0] TYPE_LUI    = 5'd6;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // ---------------------------------------------------------------- EX stage
  logic [2:0]  w_funct3;
  logic        w_alt;
  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic        w_op2_lt_s;
  logic        w_op2_lt_u;
  logic [31:0] w_sra;
  logic [31:0] w_alu;
  logic [31:0] w_addr;
  logic        w_br_eq;
  logic        w_br_lt_s;
  logic        w_br_lt_u;
  logic        w_br_taken;
  logic [31:0] w_ex_result;

  assign w_funct3   = Inst_In[14:12];
  assign w_alt      = Inst_In[30];
  assign w_op2      = (Inst_Type_In == TYPE_R_ALU) ? Operand_B_val_In : Immx_Data_In;
  assign w_shamt    = w_op2[4:0];
  assign w_sum      = Operand_A_val_In + w_op2;
  assign w_diff     = Operand_A_val_In - w_op2;
  assign w_op2_lt_s = $signed(Operand_A_val_In) < $signed(w_op2);
  assign w_op2_lt_u = Operand_A_val_In < w_op2;
  assign w_sra      = $unsigned($signed(Operand_A_val_In) >>> w_shamt);

  // Load/store address uses the immediate regardless of class encoding.
  assign w_addr     = Operand_A_val_In + Immx_Data_In;

  // Branch comparisons are always rs1 vs rs2, never the immediate.
  assign w_br_eq    = Operand_A_val_In == Operand_B_val_In;
  assign w_br_lt_s  = $signed(Operand_A_val_In) < $signed(Operand_B_val_In);
  assign w_br_lt_u  = Operand_A_val_In < Operand_B_val_In;

  always_comb begin
    w_alu = '0;
    case (w_funct3)
      // SUB exists only in the register form; ADDI ignores bit30.
      F3_ADD:  w_alu = (Inst_Type_In == TYPE_R_ALU && w_alt) ? w_diff : w_sum;
      F3_SLL:  w_alu = Operand_A_val_In << w_shamt;
      F3_SLT:  w_alu = {31'b0, w_op2_lt_s};
      F3_SLTU: w_alu = {31'b0, w_op2_lt_u};
      F3_XOR:  w_alu = Operand_A_val_In ^ w_op2;
      F3_SR:   w_alu = w_alt ? w_sra : (Operand_A_val_In >> w_shamt);
      F3_OR:   w_alu = Operand_A_val_In | w_op2;
      F3_AND:  w_alu = Operand_A_val_In & w_op2;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_br_taken = w_br_eq;
      3'b001:  w_br_taken = ~w_br_eq;
      3'b100:  w_br_taken = w_br_lt_s;
      3'b101:  w_br_taken = ~w_br_lt_s;
      3'b110:  w_br_taken = w_br_lt_u;
      3'b111:  w_br_taken = ~w_br_lt_u;
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_ex_result          = '0;
    EX_isBranchTaken_Out = 1'b0;
    case (Inst_Type_In)
      TYPE_R_ALU,
      TYPE_I_ALU:  w_ex_result = w_alu;
      TYPE_LOAD,
      TYPE_STORE:  w_ex_result = w_addr;
      TYPE_BRANCH: begin
        // Target is pre-computed upstream as an absolute byte address.
        w_ex_result          = Immx_Data_In;
        EX_isBranchTaken_Out = w_br_taken;
      end
      TYPE_LUI:    w_ex_result = Immx_Data_In;
      default:     w_ex_result = '0;
    endcase
  end

  assign EX_Result_Out = w_ex_result;

  // -------------------------------------------------------- EX/MA register
  logic [31:0] r_result;
  logic [31:0] r_inst;
  logic [4:0]  r_type;
  logic [31:0] r_store_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result     <= '0;
      r_inst       <= '0;
      r_type       <= TYPE_NOP;
      r_store_data <= '0;
    end else begin
      r_result     <= w_ex_result;
      r_inst       <= Inst_In;
      r_type       <= Inst_Type_In;
      r_store_data <= Operand_B_val_In;
    end
  end

  // ---------------------------------------------------------------- MA stage
  // Storage is deliberately outside the reset domain: rst_n only clears the
  // pipeline register, never the data held in memory. Power-up contents come
  // from the target's memory initialisation (zero).
  logic [31:0]      r_mem [MEM_WORDS];
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_data;

  // Byte offset [1:0] and bits above the index are dropped, so addresses alias.
  assign w_idx     = r_result[IDX_W+1:2];
  assign w_rd_data = r_mem[w_idx];

  // Read is combinational from the current array, so a same-edge write is
  // only seen on the following cycle.
  always_ff @(posedge clk) begin
    if (rst_n && r_type == TYPE_STORE) begin
      r_mem[w_idx] <= r_store_data;
    end
  end

  assign MA_Register_Data_Out = (r_type == TYPE_LOAD) ? w_rd_data : r_result;
  assign MA_Inst_Out          = r_inst;
  assign EX_MA_Inst_Type_Out  = r_type;

endmodule

// File: tb/tb_ex_ma_datapath.sv
module tb_ex_ma_datapath;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] imm;
  logic [4:0]  typ;
  logic        ex_taken;
  logic [31:0] ex_res;
  logic [31:0] ma_data;
  logic [31:0] ma_inst;
  logic [4:0]  ma_type;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the EX/MA register and the memory should hold.
  logic [31:0] m_res;
  logic [31:0] m_inst;
  logic [4:0]  m_type;
  logic [31:0] m_b;
  logic [31:0] m_mem [256];

  ex_ma_datapath #(.MEM_WORDS(256)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .Inst_In              (inst),
    .Operand_A_val_In     (a),
    .Operand_B_val_In     (b),
    .Immx_Data_In         (imm),
    .Inst_Type_In         (typ),
    .EX_isBranchTaken_Out (ex_taken),
    .EX_Result_Out        (ex_res),
    .MA_Register_Data_Out (ma_data),
    .MA_Inst_Out          (ma_inst),
    .EX_MA_Inst_Type_Out  (ma_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic alt);
    logic [31:0] x;
    x = 32'h0000_0033;
    x[14:12] = f3;
    x[30] = alt;
    return x;
  endfunction

  // Architectural meaning of each class, written from the instruction rules.
  function automatic void ex_model(input logic [4:0] t, input logic [31:0] ins,
                                   input logic [31:0] ra, input logic [31:0] rb,
                                   input logic [31:0] ri,
                                   output logic [31:0] res, output logic tk);
    logic [31:0] o2;
    logic [4:0]  sh;
    logic [2:0]  f3;
    int          sa;
    int          so;
    res = 32'd0;
    tk  = 1'b0;
    f3  = ins[14:12];
    case (t)
      5'd1, 5'd2: begin
        o2 = (t == 5'd1) ? rb : ri;
        sh = o2[4:0];
        sa = int'($signed(ra));
        so = int'($signed(o2));
        case (f3)
          3'd0: res = (t == 5'd1 && ins[30]) ? ra - o2 : ra + o2;
          3'd1: res = ra << sh;
          3'd2: res = (sa < so) ? 32'd1 : 32'd0;
          3'd3: res = (ra < o2) ? 32'd1 : 32'd0;
          3'd4: res = ra ^ o2;
          3'd5: res = ins[30] ? 32'(sa >>> sh) : ra >> sh;
          3'd6: res = ra | o2;
          default: res = ra & o2;
        endcase
      end
      5'd3, 5'd4: res = ra + ri;
      5'd5: begin
        res = ri;
        case (f3)
          3'd0: tk = (ra == rb);
          3'd1: tk = (ra != rb);
          3'd4: tk = int'($signed(ra)) <  int'($signed(rb));
          3'd5: tk = int'($signed(ra)) >= int'($signed(rb));
          3'd6: tk = ra <  rb;
          3'd7: tk = ra >= rb;
          default: tk = 1'b0;
        endcase
      end
      5'd6: res = ri;
      default: res = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ma_model();
    if (m_type == 5'd3) return m_mem[m_res[9:2]];
    return m_res;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] ri,
                       input logic [4:0] t);
    inst = ins; a = ra; b = rb; imm = ri; typ = t;
    #1;
  endtask

  // One rising edge, with the reference updated from the pre-edge inputs.
  task automatic step();
    logic [31:0] r;
    logic        tk;
    @(posedge clk);
    ex_model(typ, inst, a, b, imm, r, tk);
    if (rst_n && m_type == 5'd4) m_mem[m_res[9:2]] = m_b;
    if (!rst_n) begin
      m_res = 0; m_inst = 0; m_type = 0; m_b = 0;
    end else begin
      m_res = r; m_inst = inst; m_type = typ; m_b = b;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(mk_inst(3'd0, 1'b0), 32'd7, 32'd5, 32'd0, 5'd1);
    step();
    step();
    n_checks++;
    if (ma_inst !== 32'd0) begin
      n_fail++; $display("FAIL reset_inst: got %h, required %h", ma_inst, 32'd0);
    end
    n_checks++;
    if (ma_type !== 5'd0) begin
      n_fail++; $display("FAIL reset_type: got %0d, required 0", ma_type);
    end
    n_checks++;
    if (ma_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", ma_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_r_alu();
    logic [31:0] ins;
    ins = mk_inst(3'd0, 1'b0);
    drive(ins, 32'd7, 32'd5, 32'd0, 5'd1);
    n_checks++;
    if (ex_res !== 32'd12) begin
      n_fail++; $display("FAIL add_ex: got %h, required %h", ex_res, 32'd12);
    end
    step();
    n_checks++;
    if (ma_data !== 32'd12) begin
      n_fail++; $display("FAIL add_ma: got %h, required %h", ma_data, 32'd12);
    end
    n_checks++;
    if (ma_inst !== ins || ma_type !== 5'd1) begin
      n_fail++; $display("FAIL add_ma_inst: got %h/%0d, required %h/1", ma_inst, ma_type, ins);
    end
    drive(mk_inst(3'd0, 1'b1), 32'd7, 32'd5, 32'd0, 5'd1);
    n_checks++;
    if (ex_res !== 32'd2) begin
      n_fail++; $display("FAIL sub_ex: got %h, required %h", ex_res, 32'd2);
    end
    step();
    n_checks++;
    if (ma_data !== 32'd2) begin
      n_fail++; $display("FAIL sub_ma: got %h, required %h", ma_data, 32'd2);
    end
    drive(mk_inst(3'd5, 1'b1), 32'h8000_0000, 32'd4, 32'd0, 5'd1);
    n_checks++;
    if (ex_res !== 32'hF800_0000) begin
      n_fail++; $display("FAIL sra_ex: got %h, required %h", ex_res, 32'hF800_0000);
    end
    step();
  endtask

  task automatic test_i_alu();
    drive(mk_inst(3'd2, 1'b0), 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (ex_res !== 32'd1) begin
      n_fail++; $display("FAIL slti_ex: got %h, required 1", ex_res);
    end
    step();
    drive(mk_inst(3'd3, 1'b0), 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2);
    n_checks++;
    if (ex_res !== 32'd0) begin
      n_fail++; $display("FAIL sltiu_ex: got %h, required 0", ex_res);
    end
    step();
  endtask

  task automatic test_store_load();
    drive(mk_inst(3'd2, 1'b0), 32'h100, 32'hDEAD_BEEF, 32'd4, 5'd4);
    n_checks++;
    if (ex_res !== 32'h104) begin
      n_fail++; $display("FAIL store_addr: got %h, required %h", ex_res, 32'h104);
    end
    step();
    drive(mk_inst(3'd2, 1'b0), 32'h104, 32'd0, 32'd0, 5'd3);
    step();
    n_checks++;
    if (ma_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_back: got %h, required %h", ma_data, 32'hDEAD_BEEF);
    end
    drive(mk_inst(3'd2, 1'b0), 32'h504, 32'd0, 32'd0, 5'd3);
    step();
    n_checks++;
    if (ma_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_alias: got %h, required %h", ma_data, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_branch();
    drive(mk_inst(3'd0, 1'b0), 32'd3, 32'd3, 32'h40, 5'd5);
    n_checks++;
    if (ex_taken !== 1'b1 || ex_res !== 32'h40) begin
      n_fail++; $display("FAIL beq_taken: got %b/%h, required 1/%h", ex_taken, ex_res, 32'h40);
    end
    drive(mk_inst(3'd0, 1'b0), 32'd3, 32'd4, 32'h40, 5'd5);
    n_checks++;
    if (ex_taken !== 1'b0) begin
      n_fail++; $display("FAIL beq_not: got %b, required 0", ex_taken);
    end
    drive(mk_inst(3'd6, 1'b0), 32'd1, 32'hFFFF_FFFF, 32'h80, 5'd5);
    n_checks++;
    if (ex_taken !== 1'b1) begin
      n_fail++; $display("FAIL bltu: got %b, required 1", ex_taken);
    end
    drive(mk_inst(3'd4, 1'b0), 32'd1, 32'hFFFF_FFFF, 32'h80, 5'd5);
    n_checks++;
    if (ex_taken !== 1'b0) begin
      n_fail++; $display("FAIL blt: got %b, required 0", ex_taken);
    end
    drive(mk_inst(3'd0, 1'b0), 32'd3, 32'd3, 32'h40, 5'd1);
    n_checks++;
    if (ex_taken !== 1'b0) begin
      n_fail++; $display("FAIL nonbranch_taken: got %b, required 0", ex_taken);
    end
    step();
  endtask

  task automatic test_reset_store();
    drive(mk_inst(3'd2, 1'b0), 32'h200, 32'h11, 32'd0, 5'd4);
    step();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    drive(mk_inst(3'd2, 1'b0), 32'h200, 32'h55, 32'd0, 5'd4);
    step();
    rst_n = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    step();
    n_checks++;
    if (ma_type !== 5'd0 || ma_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_clears_store: got %0d/%h, required 0/0", ma_type, ma_data);
    end
    rst_n = 1'b1;
    drive(mk_inst(3'd2, 1'b0), 32'h200, 32'd0, 32'd0, 5'd3);
    step();
    n_checks++;
    if (ma_data !== 32'h11) begin
      n_fail++; $display("FAIL reset_no_write: got %h, required %h", ma_data, 32'h11);
    end
  endtask

  task automatic test_lui();
    drive(32'h1234_5037, 32'hFFFF_FFFF, 32'd9, 32'h1234_5000, 5'd6);
    n_checks++;
    if (ex_res !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_ex: got %h, required %h", ex_res, 32'h1234_5000);
    end
    step();
    n_checks++;
    if (ma_data !== 32'h1234_5000) begin
      n_fail++; $display("FAIL lui_ma: got %h, required %h", ma_data, 32'h1234_5000);
    end
  endtask

  task automatic test_random();
    logic [31:0] er;
    logic        et;
    logic [31:0] ins;
    logic [4:0]  t;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ri;
    // Give the random address window (words 160..191) known contents.
    for (int i = 0; i < 32; i++) begin
      drive(mk_inst(3'd2, 1'b0), 32'h280 + 32'(i * 4), $urandom, 32'd0, 5'd4);
      step();
    end
    for (int n = 0; n < 400; n++) begin
      t   = 5'($urandom_range(0, 9));
      ins = $urandom;
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      ri  = $urandom;
      if ($urandom_range(0, 3) == 0) ri = 32'($urandom_range(0, 40));
      if (t == 5'd3 || t == 5'd4) begin
        ra = 32'h280 + 32'($urandom_range(0, 63));
        ri = 32'($urandom_range(0, 63)) + 32'h400 * 32'($urandom_range(0, 3));
      end
      rst_n = ($urandom_range(0, 24) != 0);
      drive(ins, ra, rb, ri, t);
      ex_model(t, ins, ra, rb, ri, er, et);
      n_checks++;
      if (ex_res !== er || ex_taken !== et) begin
        n_fail++;
        $display("FAIL rand_ex[%0d] type=%0d inst=%h a=%h b=%h imm=%h: got %h/%b, required %h/%b",
                 n, t, ins, ra, rb, ri, ex_res, ex_taken, er, et);
      end
      step();
      n_checks++;
      if (ma_data !== ma_model() || ma_inst !== m_inst || ma_type !== m_type) begin
        n_fail++;
        $display("FAIL rand_ma[%0d]: got %h/%h/%0d, required %h/%h/%0d",
                 n, ma_data, ma_inst, ma_type, ma_model(), m_inst, m_type);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    m_res = 0; m_inst = 0; m_type = 0; m_b = 0;
    rst_n = 1'b0;
    inst = 0; a = 0; b = 0; imm = 0; typ = 0;
    test_reset();
    test_r_alu();
    test_i_alu();
    test_store_load();
    test_branch();
    test_reset_store();
    test_lui();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_ma_datapath.md
Name: ex_ma_datapath

Overview:
- Execute and memory-access slice of the 5-stage pipeline: combinational EX (ALU + branch resolution), the EX/MA pipeline register, and the MA stage (word data memory).
- Sits between the ID/EX register and the MA/RW register.
- Branch outcome and target leave EX combinationally and go back to instruction fetch and the flush logic.

Parameters:
- MEM_WORDS, 256, number of 32-bit data-memory words; index = address[log2(MEM_WORDS)+1:2].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Inst_In  in  32  instruction from ID/EX (RV32 encoding; funct3=[14:12], bit30 = funct7 alt)
- Operand_A_val_In  in  32  rs1 value
- Operand_B_val_In  in  32  rs2 value
- Immx_Data_In  in  32  sign-extended immediate (already shifted for LUI)
- Inst_Type_In  in  5  instruction class
- EX_isBranchTaken_Out  out  1  combinational branch-taken flag
- EX_Result_Out  out  32  combinational ALU result / branch target
- MA_Register_Data_Out  out  32  value destined for the register file
- MA_Inst_Out  out  32  instruction held in the EX/MA register
- EX_MA_Inst_Type_Out  out  5  class held in the EX/MA register

Behaviour:
- Inst_Type encoding:
  - 0 NOP, 1 R_ALU, 2 I_ALU, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI.
  - Codes 7-31 behave as NOP.
- EX (purely combinational):
  - R_ALU: second operand = B. I_ALU: second operand = Imm.
  - ALU op by funct3:
    - 000: ADD; SUB only if R_ALU and bit30=1.
    - 001: SLL, shift amount = operand[4:0].
    - 010: SLT (signed). 011: SLTU.
    - 100: XOR.
    - 101: SRL; SRA if bit30=1 (applies to both R and I).
    - 110: OR. 111: AND.
    - Arithmetic wraps mod 2^32. SLT/SLTU produce 0 or 1.
  - LOAD/STORE: Result = A + Imm (byte address, wraps).
  - LUI: Result = Imm.
  - BRANCH:
    - Result = Imm (absolute byte target).
    - Taken by funct3: 000 A==B; 001 A!=B; 100 A<B signed; 101 A>=B signed; 110 A<B unsigned; 111 A>=B unsigned.
    - Taken = 0 for funct3 010/011.
  - isBranchTaken = 0 for every non-BRANCH class.
  - NOP/unknown: Result = 0.
- EX/MA register, updated on the rising clk edge:
  - Captures Result, Inst, class and B (store data).
  - rst_n=0 at an edge: all fields cleared to 0, so outputs read Inst=0, class=NOP, MA data=0.
  - No stall, no kill input.
- MA stage:
  - LOAD: MA_Register_Data_Out = mem[index] via combinational read.
  - All other classes: MA_Register_Data_Out = registered Result.
  - MA_Inst_Out = registered Inst.
  - Word access only; address bits [1:0] ignored; upper address bits beyond the index ignored (wrap-around).
- STORE write:
  - On the rising edge while the register holds STORE and rst_n=1: mem[index] <= registered B.
  - No write while rst_n=0.
- Read/write timing:
  - Write and read in the same cycle to the same word: read returns the old value; the new value is visible the next cycle.
- Memory contents:
  - Zero-initialised at power-up.
  - Not cleared by rst_n.
- Latency:
  - EX outputs: 0 cycles.
  - MA outputs: valid 1 cycle after EX inputs (after the capturing edge).

Test Plan:
- Reset: hold rst_n=0 for 2 edges -> MA_Inst_Out=0, EX_MA_Inst_Type_Out=0, MA_Register_Data_Out=0.
- R_ALU with A=7, B=5:
  - funct3=000, bit30=0 -> EX_Result=12, next cycle MA data=12.
  - bit30=1 -> 2.
  - A=0x80000000, funct3=101, bit30=1, B=4 -> 0xF8000000.
- I_ALU SLT with A=-1, Imm=0 -> 1; SLTU with the same operands -> 0.
- STORE A=0x100, Imm=4, B=0xDEADBEEF, then LOAD A=0x104, Imm=0 the next cycle -> MA data=0xDEADBEEF; a load at 0x504 with MEM_WORDS=256 aliases to the same word.
- BRANCH funct3=000, A=B=3, Imm=0x40 -> EX_isBranchTaken=1, EX_Result=0x40; A=3, B=4 -> taken=0; BLTU with A=1, B=0xFFFFFFFF -> taken=1; BLT with the same operands -> 0.
- rst_n=0 asserted while a STORE is held in the register -> memory word unchanged; LUI Imm=0x12345000 -> MA data=0x12345000.
